// File: rtl/avmm_wr_ack_word_to_burst.sv
// Collapses per-word AVMM write acks into one ack per burst, using a FIFO of snooped burstcounts.
// Optional protocol checking is enabled by defining AVMM_WR_ACK_W2B_ERR_CHECK_EN.
module avmm_wr_ack_word_to_burst #(
  parameter int AVMM_BURSTCNT_WIDTH = 5,
  parameter int FIFO_DEPTH          = 64,
  parameter int OUTST_W             = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cmd_write,
  input  logic                           cmd_waitrequest,
  input  logic [AVMM_BURSTCNT_WIDTH-1:0] cmd_burstcnt,
  input  logic                           per_word_write_ack_in,
  output logic                           per_burst_write_ack_out,
  output logic                           wr_stall,
  output logic [OUTST_W-1:0]             outstanding_bursts,
  output logic                           ack_err
);

  localparam int W     = AVMM_BURSTCNT_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [OUTST_W-1:0] DEPTH_CNT = OUTST_W'(FIFO_DEPTH);

  // Handshake: a command beat is accepted on any cycle with cmd_write=1 and
  // cmd_waitrequest=0; there is no other qualifier. Word acks are single-cycle
  // pulses with no backpressure, and the burst ack is a single-cycle pulse.

  logic [W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OUTST_W-1:0] count, count_next;
  logic [W-1:0]       beat_cnt, word_ack_cnt, head, push_val;
  logic               beat_acc, burst_start, fifo_full, fifo_empty, pop, push;

  assign beat_acc    = cmd_write & ~cmd_waitrequest;
  assign burst_start = beat_acc & (beat_cnt == '0);
  // A zero burstcount is treated as a single-word burst.
  assign push_val    = (cmd_burstcnt == '0) ? W'(1) : cmd_burstcnt;
  assign fifo_full   = (count == DEPTH_CNT);
  assign fifo_empty  = (count == '0);
  assign head        = mem[rd_ptr];
  assign pop         = per_word_write_ack_in & ~fifo_empty & ((word_ack_cnt + W'(1)) == head);
  // Popping frees a slot this same cycle, so a full FIFO can still accept a start.
  assign push        = burst_start & (~fifo_full | pop);

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + OUTST_W'(1);
    else if (pop && !push) count_next = count - OUTST_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      count                   <= '0;
      wr_stall                <= 1'b0;
      beat_cnt                <= '0;
      word_ack_cnt            <= '0;
      per_burst_write_ack_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_next;
      wr_stall <= (count_next == DEPTH_CNT);
      if (burst_start)   beat_cnt <= push_val - W'(1);
      else if (beat_acc) beat_cnt <= beat_cnt - W'(1);
      if (pop)                                      word_ack_cnt <= '0;
      else if (per_word_write_ack_in && !fifo_empty) word_ack_cnt <= word_ack_cnt + W'(1);
      per_burst_write_ack_out <= pop;
    end
  end

  assign outstanding_bursts = count;

`ifdef AVMM_WR_ACK_W2B_ERR_CHECK_EN
  logic err_event;
  // Underflow ack, dropped start on a full FIFO, or zero burstcount.
  assign err_event = (per_word_write_ack_in & fifo_empty)
                   | (burst_start & fifo_full & ~pop)
                   | (burst_start & (cmd_burstcnt == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       ack_err <= 1'b0;
    else if (err_event) ack_err <= 1'b1;
  end
`else
  assign ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_avmm_wr_ack_word_to_burst.sv
// Bench for avmm_wr_ack_word_to_burst: queue-based reference model plus burst-ack scoreboard.
module tb_avmm_wr_ack_word_to_burst;
  localparam int W     = 5;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_write = 1'b0;
  logic          cmd_waitrequest = 1'b0;
  logic [W-1:0]  cmd_burstcnt = '0;
  logic          ack_in = 1'b0;
  logic          burst_ack;
  logic          wr_stall;
  logic [OW-1:0] outstanding;
  logic          ack_err;

  avmm_wr_ack_word_to_burst #(
    .AVMM_BURSTCNT_WIDTH(W), .FIFO_DEPTH(DEPTH), .OUTST_W(OW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_write(cmd_write), .cmd_waitrequest(cmd_waitrequest),
    .cmd_burstcnt(cmd_burstcnt), .per_word_write_ack_in(ack_in),
    .per_burst_write_ack_out(burst_ack), .wr_stall(wr_stall),
    .outstanding_bursts(outstanding), .ack_err(ack_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int vectors = 0;
  int miscompares = 0;

  // reference model: queue of burst lengths still waiting for their burst ack
  int          q[$];
  int          acks_seen = 0;
  int          beats_left = 0;
  int          owed = 0;
  logic        err_m = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_q.delete();
    acks_seen  = 0;
    beats_left = 0;
    owed       = 0;
    err_m      = 1'b0;
  endtask

  // one clock of stimulus; model predicts the effect of the coming edge
  task automatic step(input logic w, input logic wt, input logic [W-1:0] bc, input logic ack);
    logic accepted, start;
    int   eff;
    cmd_write = w; cmd_waitrequest = wt; cmd_burstcnt = bc; ack_in = ack;
    accepted = w && !wt;
    start    = accepted && (beats_left == 0);
    if (ack) begin
      if (q.size() > 0) begin
        owed--;
        if (acks_seen + 1 == q[0]) begin
          void'(q.pop_front());
          acks_seen = 0;
          exp_q.push_back(32'(cyc + 1));
        end else acks_seen++;
      end else err_m = 1'b1;
    end
    eff = (bc == 0) ? 1 : int'(bc);
    if (start) begin
      if (q.size() < DEPTH) begin
        q.push_back(eff);
        owed += eff;
      end else err_m = 1'b1;
      if (bc == 0) err_m = 1'b1;
      beats_left = eff - 1;
    end else if (accepted) beats_left--;
    @(posedge clk);
    #1;
    chk("outstanding", int'(outstanding), q.size());
    chk("wr_stall", int'(wr_stall), int'(q.size() == DEPTH));
`ifdef AVMM_WR_ACK_W2B_ERR_CHECK_EN
    chk("ack_err", int'(ack_err), int'(err_m));
`else
    chk("ack_err", int'(ack_err), 0);
`endif
    cmd_write = 1'b0; ack_in = 1'b0;
  endtask

  task automatic do_reset();
    cmd_write = 1'b0; ack_in = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_burst_ack", int'(burst_ack), 0);
    chk("rst_wr_stall", int'(wr_stall), 0);
    chk("rst_outstanding", int'(outstanding), 0);
    chk("rst_ack_err", int'(ack_err), 0);
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // scoreboard monitor: every burst-ack pulse must match the next expected cycle
  always @(negedge clk) begin
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0] < 32'(cyc)) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_burst_ack: got none expected pulse at cyc %0d", exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (burst_ack) begin
        if (exp_q.size() == 0) chk("unexpected_burst_ack", cyc, -1);
        else chk("burst_ack_cycle", cyc, int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("init_burst_ack", int'(burst_ack), 0);
    chk("init_wr_stall", int'(wr_stall), 0);
    chk("init_outstanding", int'(outstanding), 0);
    chk("init_ack_err", int'(ack_err), 0);
    reset_n = 1'b1;

    // single burst of 4
    repeat (4) step(1, 0, 4, 0);
    repeat (4) step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // bursts 1, 8, 2 then 11 contiguous acks
    step(1, 0, 1, 0);
    repeat (8) step(1, 0, 8, 0);
    repeat (2) step(1, 0, 2, 0);
    repeat (11) step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // fill to full, release one burst
    repeat (8) step(1, 0, 2, 0);
    repeat (2) step(0, 0, 0, 1);
    // refill, then pop and push on the same edge while full
    repeat (2) step(1, 0, 2, 0);
    step(0, 0, 0, 1);
    step(1, 0, 2, 1);
    step(1, 0, 2, 0);
    repeat (8) step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // reset in the middle of a burst of 8, then in-flight acks
    step(1, 0, 8, 0);
    step(1, 0, 8, 1);
    step(1, 0, 8, 1);
    do_reset();
    repeat (2) step(0, 0, 0, 1);
    repeat (2) step(1, 0, 2, 0);
    repeat (2) step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // underflow ack on an empty FIFO, then check it is held
    do_reset();
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);

    // start while full is dropped
    do_reset();
    repeat (4) step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    repeat (4) step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // zero burstcount behaves as one word
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // randomized traffic
    do_reset();
    begin
      logic [W-1:0] bc;
      logic         w, wt, a;
      bc = 1;
      for (int i = 0; i < 400; i++) begin
        w  = ($urandom_range(0, 3) != 0);
        wt = ($urandom_range(0, 3) == 0);
        if (beats_left == 0) begin
          bc = W'($urandom_range(1, 16));
          if (q.size() == DEPTH) wt = 1'b1;
        end
        a = (owed > 0) && ($urandom_range(0, 2) != 0);
        step(w, wt, bc, a);
      end
      for (int i = 0; i < 2000 && (beats_left != 0 || owed != 0); i++) begin
        a  = (owed > 0);
        wt = (q.size() == DEPTH) && (beats_left == 0);
        step(beats_left != 0, wt, bc, a);
      end
      chk("drain_done", int'(beats_left != 0 || owed != 0), 0);
    end
    repeat (3) step(0, 0, 0, 0);
    chk("pending_expected_acks", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
